// File: rtl/debounce_edge_detect.sv
// Raw-input conditioner: synchronizer, glitch-rejecting debouncer and
// registered rise/fall pulse generator feeding the downstream D-flop stage.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   d_in       in   raw asynchronous input
//   q          out  debounced registered level
//   rise       out  one-cycle pulse on q 0->1
//   fall       out  one-cycle pulse on q 1->0
//   busy       out  high while a change is being qualified (CHECK)
//   glitch_cnt out  saturating count of rejected glitches
//                   (only when DEBOUNCE_GLITCH_CNT_EN is defined)
//
// Parameters:
//   SYNC_STAGES     synchronizer depth, 2..4
//   DEBOUNCE_CYCLES consecutive differing samples before q moves, >= 1
//   CNT_W           qualify counter width, 2**CNT_W > DEBOUNCE_CYCLES
module debounce_edge_detect #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       d_in,
  output logic       q,
  output logic       rise,
  output logic       fall,
  output logic       busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_out;

  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   lvl_q;
  logic                   rise_q;
  logic                   fall_q;

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0]             gcnt_q;
`endif

  // Only sync_q[0] may go metastable; later stages see a settled value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_in};
    end
  end

  assign s_out = sync_q[SYNC_STAGES-1];

  // Debounce FSM. Pulses default low each cycle so they last one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
      gcnt_q  <= '0;
`endif
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      unique case (state_q)
        ST_STABLE: begin
          if (s_out != lvl_q) begin
            if (DEBOUNCE_CYCLES == 1) begin
              // Single-sample qualification: accept immediately.
              lvl_q  <= s_out;
              rise_q <= s_out;
              fall_q <= ~s_out;
            end else begin
              state_q <= ST_CHECK;
              cnt_q   <= CNT_ONE;
            end
          end
        end
        ST_CHECK: begin
          if (s_out == lvl_q) begin
            // Input fell back before qualifying: a glitch.
            state_q <= ST_STABLE;
            cnt_q   <= '0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
            if (gcnt_q != 8'hFF) begin
              gcnt_q <= gcnt_q + 8'd1;
            end
`endif
          end else if (cnt_q == CNT_MAX) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            lvl_q   <= s_out;
            rise_q  <= s_out;
            fall_q  <= ~s_out;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= ST_STABLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign q    = lvl_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = (state_q == ST_CHECK);

`ifdef DEBOUNCE_GLITCH_CNT_EN
  assign glitch_cnt = gcnt_q;
`endif

endmodule

// File: tb/tb_debounce_edge_detect.sv
// Directed self-checking bench for debounce_edge_detect.
// Covers reset, clean edges, glitches, reset mid-qualify and corners.
module tb_debounce_edge_detect;

  logic clk;
  logic reset;
  logic d_in;
  logic q, rise, fall, busy;
  logic d_in2;
  logic q2, rise2, fall2, busy2;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
  logic [7:0] glitch_cnt2;
`endif

  int errors = 0;
  int checks = 0;

  debounce_edge_detect u_dut (
    .clk   (clk),
    .reset (reset),
    .d_in  (d_in),
    .q     (q),
    .rise  (rise),
    .fall  (fall),
    .busy  (busy)
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_cnt (glitch_cnt)
`endif
  );

  debounce_edge_detect #(
    .SYNC_STAGES     (3),
    .DEBOUNCE_CYCLES (1)
  ) u_corner (
    .clk   (clk),
    .reset (reset),
    .d_in  (d_in2),
    .q     (q2),
    .rise  (rise2),
    .fall  (fall2),
    .busy  (busy2)
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_cnt (glitch_cnt2)
`endif
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    d_in  = 1'b1;
    d_in2 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #10;
      checks++;
      if ({q, rise, fall, busy} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_hold t=%0t q/rise/fall/busy=%b want 0000",
                 $time, {q, rise, fall, busy});
      end
    end
  endtask

  task automatic test_clean_rise();
    logic eq, er, eb;
    step();
    reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      eq = (k >= 6);
      er = (k == 6);
      eb = (k >= 3 && k <= 5);
      checks++;
      if ({q, rise, fall, busy} !== {eq, er, 1'b0, eb}) begin
        errors++;
        $display("FAIL clean_rise edge=%0d q/rise/fall/busy=%b want %b",
                 k, {q, rise, fall, busy}, {eq, er, 1'b0, eb});
      end
    end
  endtask

  task automatic test_glitch();
    logic seen_busy;
    seen_busy = 1'b0;
    d_in = 1'b0;
    step();
    step();
    d_in = 1'b1;
    for (int k = 3; k <= 9; k++) begin
      step();
      seen_busy |= busy;
      checks++;
      if ({q, rise, fall} !== 3'b100) begin
        errors++;
        $display("FAIL glitch edge=%0d q/rise/fall=%b want 100",
                 k, {q, rise, fall});
      end
    end
    checks++;
    if (seen_busy !== 1'b1) begin
      errors++;
      $display("FAIL glitch_busy seen=%b want 1", seen_busy);
    end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    checks++;
    if (glitch_cnt !== 8'd1) begin
      errors++;
      $display("FAIL glitch_cnt got=%0d want 1", glitch_cnt);
    end
`endif
  endtask

  task automatic test_clean_fall();
    logic eq, ef;
    d_in = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      eq = (k < 6);
      ef = (k == 6);
      checks++;
      if ({q, rise, fall} !== {eq, 1'b0, ef}) begin
        errors++;
        $display("FAIL clean_fall edge=%0d q/rise/fall=%b want %b",
                 k, {q, rise, fall}, {eq, 1'b0, ef});
      end
    end
  endtask

  task automatic test_reset_mid_check();
    logic eq, er;
    d_in = 1'b1;
    step();
    step();
    step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_check_busy got=%b want 1", busy);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({q, rise, fall, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_async q/rise/fall/busy=%b want 0000",
               {q, rise, fall, busy});
    end
    #39;
    checks++;
    if ({q, rise, fall, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_held q/rise/fall/busy=%b want 0000",
               {q, rise, fall, busy});
    end
    reset = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      eq = (k >= 6);
      er = (k == 6);
      checks++;
      if ({q, rise, fall} !== {eq, er, 1'b0}) begin
        errors++;
        $display("FAIL reset_resume edge=%0d q/rise/fall=%b want %b",
                 k, {q, rise, fall}, {eq, er, 1'b0});
      end
    end
  endtask

  task automatic test_param_corner();
    logic eq, er, ef, any_busy;
    any_busy = 1'b0;
    d_in2 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      any_busy |= busy2;
      eq = (k >= 4);
      er = (k == 4);
      checks++;
      if ({q2, rise2, fall2} !== {eq, er, 1'b0}) begin
        errors++;
        $display("FAIL corner_rise edge=%0d q/rise/fall=%b want %b",
                 k, {q2, rise2, fall2}, {eq, er, 1'b0});
      end
    end
    d_in2 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      any_busy |= busy2;
      eq = (k < 4);
      ef = (k == 4);
      checks++;
      if ({q2, rise2, fall2} !== {eq, 1'b0, ef}) begin
        errors++;
        $display("FAIL corner_fall edge=%0d q/rise/fall=%b want %b",
                 k, {q2, rise2, fall2}, {eq, 1'b0, ef});
      end
    end
    checks++;
    if (any_busy !== 1'b0) begin
      errors++;
      $display("FAIL corner_busy got=%b want 0", any_busy);
    end
  endtask

  task automatic test_glitch_saturate();
    logic moved;
    moved = 1'b0;
    d_in = 1'b1;
    for (int g = 0; g < 300; g++) begin
      d_in = 1'b0;
      step();
      moved |= (q !== 1'b1) | fall;
      step();
      moved |= (q !== 1'b1) | fall;
      d_in = 1'b1;
      for (int j = 0; j < 5; j++) begin
        step();
        moved |= (q !== 1'b1) | fall;
      end
    end
    checks++;
    if (moved !== 1'b0) begin
      errors++;
      $display("FAIL storm_q_moved got=%b want 0", moved);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL storm_busy got=%b want 0", busy);
    end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    checks++;
    if (glitch_cnt !== 8'd255) begin
      errors++;
      $display("FAIL glitch_sat got=%0d want 255", glitch_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_clean_rise();
    test_glitch();
    test_clean_fall();
    test_reset_mid_check();
    test_param_corner();
    test_glitch_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
